mem_wb_stage: RTL and testbench

- Consumer of the EX/MEM pipeline register outputs. Performs the MEM-stage data-memory access over a req/ready handshake, resolves the branch/jump redirect, and holds the MEM/WB pipeline register that feeds write-back.
- Stalls upstream while a memory access is outstanding. A watchdog aborts accesses that never complete.

---
 rtl/mem_wb_stage.sv | 206 ++++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM stage with data-memory handshake, branch/jump redirect and the MEM/WB pipeline register.
// Latency: one negedge from issue to MEM/WB when dm_ready is high the same cycle; otherwise one negedge after dm_ready.
// Backpressure: Stall holds upstream while a memory access is outstanding; a watchdog aborts after TIMEOUT_CYCLES WAIT cycles.
module mem_wb_stage #(
    parameter int DW             = 32,
    parameter int RW             = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic          CLK,
    input  logic          Resetn,
    input  logic          MemWr_i,
    input  logic          MemtoReg_i,
    input  logic          Regwr_i,
    input  logic          Branch_i,
    input  logic          Jump_i,
    input  logic          Zero_i,
    input  logic [DW-1:0] busB_i,
    input  logic [DW-1:0] ALUout_i,
    input  logic [DW-1:0] Target_i,
    input  logic [RW-1:0] Rd_i,
    output logic          dm_req,
    output logic          dm_we,
    output logic [DW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    input  logic          dm_ready,
    input  logic [DW-1:0] dm_rdata,
    output logic          Stall,
    output logic          PCSrc,
    output logic [DW-1:0] Target,
    output logic          Regwr,
    output logic          MemtoReg,
    output logic [RW-1:0] Rd,
    output logic [DW-1:0] ALUout,
    output logic [DW-1:0] MemData,
    output logic [DW-1:0] WBData,
    output logic          Err
);

    // Counter needs at least one bit even when a single WAIT cycle is allowed.
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;

    // Request fields and write-back controls held while the access is outstanding.
    logic            r_lat_we;
    logic [DW-1:0]   r_lat_addr;
    logic [DW-1:0]   r_lat_wdata;
    logic            r_lat_regwr;
    logic            r_lat_memtoreg;
    logic [RW-1:0]   r_lat_rd;
    logic [DW-1:0]   r_lat_aluout;

    // MEM/WB pipeline register.
    logic            r_regwr;
    logic            r_memtoreg;
    logic [RW-1:0]   r_rd;
    logic [DW-1:0]   r_aluout;
    logic [DW-1:0]   r_memdata;
    logic [DW-1:0]   r_wbdata;
    logic            r_err;

    logic            w_memop;
    logic            w_in_wait;
    logic            w_timeout;
    logic            w_cap_live;
    logic            w_cap_lat;
    logic            w_nxt_regwr;
    logic            w_nxt_memtoreg;
    logic [RW-1:0]   w_nxt_rd;
    logic [DW-1:0]   w_nxt_aluout;
    logic [DW-1:0]   w_nxt_memdata;

    assign w_memop   = MemWr_i | MemtoReg_i;
    assign w_in_wait = (r_state == S_WAIT);
    assign w_timeout = w_in_wait & ~dm_ready & (r_cnt == CNT_LAST);
    // Live capture: idle and either no memory op or a zero-wait completion.
    assign w_cap_live = ~w_in_wait & (~w_memop | dm_ready);
    assign w_cap_lat  = w_in_wait & dm_ready;

    // Redirect is independent of the memory handshake.
    assign PCSrc  = Jump_i | (Branch_i & Zero_i);
    assign Target = Target_i;

    // Memory request and stall: live inputs while idle, latched request while waiting.
    always_comb begin
        dm_req   = w_memop;
        dm_we    = MemWr_i;
        dm_addr  = ALUout_i;
        dm_wdata = busB_i;
        Stall    = w_memop & ~dm_ready;
        if (w_in_wait) begin
            dm_req   = 1'b1;
            dm_we    = r_lat_we;
            dm_addr  = r_lat_addr;
            dm_wdata = r_lat_wdata;
            // The timeout cycle releases upstream so the next instruction can issue.
            Stall    = ~dm_ready & ~w_timeout;
        end
    end

    // Select what MEM/WB would load on a capture; stores never return load data.
    always_comb begin
        w_nxt_regwr    = Regwr_i;
        w_nxt_memtoreg = MemtoReg_i;
        w_nxt_rd       = Rd_i;
        w_nxt_aluout   = ALUout_i;
        w_nxt_memdata  = (MemtoReg_i & ~MemWr_i) ? dm_rdata : '0;
        if (w_in_wait) begin
            w_nxt_regwr    = r_lat_regwr;
            w_nxt_memtoreg = r_lat_memtoreg;
            w_nxt_rd       = r_lat_rd;
            w_nxt_aluout   = r_lat_aluout;
            w_nxt_memdata  = r_lat_we ? '0 : dm_rdata;
        end
    end

    // FSM, watchdog counter and request latch.
    always_ff @(negedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_lat_we       <= 1'b0;
            r_lat_addr     <= '0;
            r_lat_wdata    <= '0;
            r_lat_regwr    <= 1'b0;
            r_lat_memtoreg <= 1'b0;
            r_lat_rd       <= '0;
            r_lat_aluout   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_memop && !dm_ready) begin
                        r_state        <= S_WAIT;
                        r_cnt          <= '0;
                        r_lat_we       <= MemWr_i;
                        r_lat_addr     <= ALUout_i;
                        r_lat_wdata    <= busB_i;
                        r_lat_regwr    <= Regwr_i;
                        r_lat_memtoreg <= MemtoReg_i;
                        r_lat_rd       <= Rd_i;
                        r_lat_aluout   <= ALUout_i;
                    end
                end
                S_WAIT: begin
                    if (dm_ready || w_timeout) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // MEM/WB register: load on capture, otherwise insert a bubble holding the data fields.
    always_ff @(negedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            r_regwr    <= 1'b0;
            r_memtoreg <= 1'b0;
            r_rd       <= '0;
            r_aluout   <= '0;
            r_memdata  <= '0;
            r_wbdata   <= '0;
        end else if (w_cap_live || w_cap_lat) begin
            r_regwr    <= w_nxt_regwr;
            r_memtoreg <= w_nxt_memtoreg;
            r_rd       <= w_nxt_rd;
            r_aluout   <= w_nxt_aluout;
            r_memdata  <= w_nxt_memdata;
            r_wbdata   <= w_nxt_memtoreg ? w_nxt_memdata : w_nxt_aluout;
        end else begin
            r_regwr    <= 1'b0;
            r_memtoreg <= 1'b0;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(negedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign Regwr    = r_regwr;
    assign MemtoReg = r_memtoreg;
    assign Rd       = r_rd;
    assign ALUout   = r_aluout;
    assign MemData  = r_memdata;
    assign WBData   = r_wbdata;
    assign Err      = r_err;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: table of single-cycle vectors plus stall, timeout and reset sequences.
// State changes on the falling clock edge; the bench drives and samples 1 ns after it.
// The memory model is the bench itself, driving dm_ready/dm_rdata per step.
module tb_mem_wb_stage;

    logic        CLK;
    logic        Resetn;
    logic        MemWr_i, MemtoReg_i, Regwr_i, Branch_i, Jump_i, Zero_i;
    logic [31:0] busB_i, ALUout_i, Target_i;
    logic [4:0]  Rd_i;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_ready;
    logic [31:0] dm_rdata;
    logic        Stall, PCSrc;
    logic [31:0] Target;
    logic        Regwr, MemtoReg;
    logic [4:0]  Rd;
    logic [31:0] ALUout, MemData, WBData;
    logic        Err;

    int n_checks = 0;
    int n_errors = 0;

    mem_wb_stage #(.DW(32), .RW(5), .TIMEOUT_CYCLES(4)) dut (
        .CLK(CLK), .Resetn(Resetn),
        .MemWr_i(MemWr_i), .MemtoReg_i(MemtoReg_i), .Regwr_i(Regwr_i),
        .Branch_i(Branch_i), .Jump_i(Jump_i), .Zero_i(Zero_i),
        .busB_i(busB_i), .ALUout_i(ALUout_i), .Target_i(Target_i), .Rd_i(Rd_i),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .Stall(Stall), .PCSrc(PCSrc), .Target(Target),
        .Regwr(Regwr), .MemtoReg(MemtoReg), .Rd(Rd), .ALUout(ALUout),
        .MemData(MemData), .WBData(WBData), .Err(Err)
    );

    initial CLK = 1'b1;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        memwr, m2r, regwr, branch, jump, zero, ready;
        logic [31:0] busb, alu, target, rdata;
        logic [4:0]  rd;
        // combinational expectations before the edge
        logic        e_req, e_we, e_stall, e_pcsrc;
        logic [31:0] e_addr, e_wdata;
        // MEM/WB expectations after the edge
        logic        e_regwr, e_m2r;
        logic [4:0]  e_rd;
        logic [31:0] e_memdata, e_wbdata;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        MemWr_i = 1'b0; MemtoReg_i = 1'b0; Regwr_i = 1'b0;
        Branch_i = 1'b0; Jump_i = 1'b0; Zero_i = 1'b0;
        busB_i = '0; ALUout_i = '0; Target_i = '0; Rd_i = '0;
        dm_ready = 1'b0; dm_rdata = '0;
    endtask

    task automatic apply(input vec_t v);
        MemWr_i = v.memwr; MemtoReg_i = v.m2r; Regwr_i = v.regwr;
        Branch_i = v.branch; Jump_i = v.jump; Zero_i = v.zero;
        busB_i = v.busb; ALUout_i = v.alu; Target_i = v.target; Rd_i = v.rd;
        dm_ready = v.ready; dm_rdata = v.rdata;
    endtask

    task automatic issue_load(input logic [4:0] rd, input logic [31:0] addr);
        clear_inputs();
        MemtoReg_i = 1'b1; Regwr_i = 1'b1; Rd_i = rd; ALUout_i = addr;
    endtask

    initial begin
        vt[0] = '{regwr:1'b1, rd:5'd5, alu:32'h1234, default:'0,
                  e_addr:32'h1234, e_regwr:1'b1, e_rd:5'd5, e_wbdata:32'h1234};
        vt[1] = '{m2r:1'b1, regwr:1'b1, rd:5'd3, alu:32'h40, ready:1'b1, rdata:32'hCAFEF00D, default:'0,
                  e_req:1'b1, e_addr:32'h40, e_regwr:1'b1, e_m2r:1'b1, e_rd:5'd3,
                  e_memdata:32'hCAFEF00D, e_wbdata:32'hCAFEF00D};
        vt[2] = '{memwr:1'b1, busb:32'hA5A5, alu:32'h80, ready:1'b1, rdata:32'h12345678, default:'0,
                  e_req:1'b1, e_we:1'b1, e_addr:32'h80, e_wdata:32'hA5A5, e_wbdata:32'h80};
        vt[3] = '{memwr:1'b1, m2r:1'b1, regwr:1'b1, rd:5'd9, alu:32'h100, busb:32'h77, ready:1'b1,
                  rdata:32'h1111, default:'0,
                  e_req:1'b1, e_we:1'b1, e_addr:32'h100, e_wdata:32'h77, e_regwr:1'b1, e_m2r:1'b1,
                  e_rd:5'd9};
        vt[4] = '{branch:1'b1, target:32'h200, alu:32'h10, default:'0,
                  e_addr:32'h10, e_wbdata:32'h10};
        vt[5] = '{branch:1'b1, zero:1'b1, target:32'h300, alu:32'h14, default:'0,
                  e_pcsrc:1'b1, e_addr:32'h14, e_wbdata:32'h14};
        vt[6] = '{jump:1'b1, target:32'h400, alu:32'h20, rd:5'd4, default:'0,
                  e_pcsrc:1'b1, e_addr:32'h20, e_rd:5'd4, e_wbdata:32'h20};

        // Reset state
        Resetn = 1'b0;
        clear_inputs();
        #3;
        chk("rst_regwr", {31'd0, Regwr}, 32'd0);
        chk("rst_rd", {27'd0, Rd}, 32'd0);
        chk("rst_wbdata", WBData, 32'd0);
        chk("rst_err", {31'd0, Err}, 32'd0);
        chk("rst_stall", {31'd0, Stall}, 32'd0);
        chk("rst_req", {31'd0, dm_req}, 32'd0);
        #9 Resetn = 1'b1;

        // Single-cycle table
        for (int i = 0; i < 7; i++) begin
            apply(vt[i]);
            #1;
            chk($sformatf("v%0d_req", i), {31'd0, dm_req}, {31'd0, vt[i].e_req});
            chk($sformatf("v%0d_we", i), {31'd0, dm_we}, {31'd0, vt[i].e_we});
            chk($sformatf("v%0d_addr", i), dm_addr, vt[i].e_addr);
            chk($sformatf("v%0d_wdata", i), dm_wdata, vt[i].e_wdata);
            chk($sformatf("v%0d_stall", i), {31'd0, Stall}, {31'd0, vt[i].e_stall});
            chk($sformatf("v%0d_pcsrc", i), {31'd0, PCSrc}, {31'd0, vt[i].e_pcsrc});
            chk($sformatf("v%0d_target", i), Target, vt[i].target);
            tick();
            chk($sformatf("v%0d_regwr", i), {31'd0, Regwr}, {31'd0, vt[i].e_regwr});
            chk($sformatf("v%0d_m2r", i), {31'd0, MemtoReg}, {31'd0, vt[i].e_m2r});
            chk($sformatf("v%0d_rd", i), {27'd0, Rd}, {27'd0, vt[i].e_rd});
            chk($sformatf("v%0d_aluout", i), ALUout, vt[i].alu);
            chk($sformatf("v%0d_memdata", i), MemData, vt[i].e_memdata);
            chk($sformatf("v%0d_wbdata", i), WBData, vt[i].e_wbdata);
        end

        // Reset in the middle of a WAIT
        issue_load(5'd12, 32'h40);
        #1;
        chk("rw_stall_idle", {31'd0, Stall}, 32'd1);
        tick();
        chk("rw_bubble_regwr", {31'd0, Regwr}, 32'd0);
        chk("rw_hold_rd", {27'd0, Rd}, 32'd4);
        #2 Resetn = 1'b0;
        #1;
        chk("rw_rd0", {27'd0, Rd}, 32'd0);
        chk("rw_alu0", ALUout, 32'd0);
        chk("rw_wb0", WBData, 32'd0);
        clear_inputs();
        ALUout_i = 32'h77;
        #1;
        chk("rw_req_idle", {31'd0, dm_req}, 32'd0);
        chk("rw_addr_idle", dm_addr, 32'h77);
        chk("rw_stall0", {31'd0, Stall}, 32'd0);
        #2 Resetn = 1'b1;
        clear_inputs();
        Regwr_i = 1'b1; Rd_i = 5'd5; ALUout_i = 32'h1234;
        #1;
        chk("rw_alu_stall", {31'd0, Stall}, 32'd0);
        tick();
        chk("rw_alu_regwr", {31'd0, Regwr}, 32'd1);
        chk("rw_alu_rd", {27'd0, Rd}, 32'd5);
        chk("rw_alu_wb", WBData, 32'h1234);

        // Load with three not-ready cycles
        issue_load(5'd12, 32'h40);
        #1;
        chk("ld_stall0", {31'd0, Stall}, 32'd1);
        tick();
        chk("ld_bubble0", {31'd0, Regwr}, 32'd0);
        chk("ld_hold_wb0", WBData, 32'h1234);
        // upstream changes must be ignored while waiting; redirect is not gated
        clear_inputs();
        MemWr_i = 1'b1; ALUout_i = 32'h9999; busB_i = 32'h5555; Jump_i = 1'b1;
        for (int c = 1; c < 3; c++) begin
            #1;
            chk($sformatf("ld_stall%0d", c), {31'd0, Stall}, 32'd1);
            chk($sformatf("ld_addr%0d", c), dm_addr, 32'h40);
            chk($sformatf("ld_we%0d", c), {31'd0, dm_we}, 32'd0);
            chk($sformatf("ld_pcsrc%0d", c), {31'd0, PCSrc}, 32'd1);
            tick();
            chk($sformatf("ld_bubble%0d", c), {31'd0, Regwr}, 32'd0);
            chk($sformatf("ld_hold_rd%0d", c), {27'd0, Rd}, 32'd5);
        end
        dm_ready = 1'b1; dm_rdata = 32'hDEADBEEF;
        #1;
        chk("ld_stall_done", {31'd0, Stall}, 32'd0);
        chk("ld_req_done", {31'd0, dm_req}, 32'd1);
        tick();
        chk("ld_regwr", {31'd0, Regwr}, 32'd1);
        chk("ld_m2r", {31'd0, MemtoReg}, 32'd1);
        chk("ld_rd", {27'd0, Rd}, 32'd12);
        chk("ld_memdata", MemData, 32'hDEADBEEF);
        chk("ld_wbdata", WBData, 32'hDEADBEEF);
        chk("ld_err", {31'd0, Err}, 32'd0);

        // Watchdog: memory never answers
        issue_load(5'd7, 32'h44);
        tick();
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("to_req%0d", c), {31'd0, dm_req}, 32'd1);
            chk($sformatf("to_stall%0d", c), {31'd0, Stall}, 32'd1);
            tick();
        end
        #1;
        chk("to_req_last", {31'd0, dm_req}, 32'd1);
        chk("to_stall_last", {31'd0, Stall}, 32'd0);
        chk("to_err_before", {31'd0, Err}, 32'd0);
        tick();
        chk("to_err", {31'd0, Err}, 32'd1);
        chk("to_bubble", {31'd0, Regwr}, 32'd0);
        clear_inputs();
        Regwr_i = 1'b1; Rd_i = 5'd6; ALUout_i = 32'h66;
        #1;
        chk("to_req_dropped", {31'd0, dm_req}, 32'd0);
        chk("to_next_stall", {31'd0, Stall}, 32'd0);
        tick();
        chk("to_next_regwr", {31'd0, Regwr}, 32'd1);
        chk("to_next_rd", {27'd0, Rd}, 32'd6);
        chk("to_next_wb", WBData, 32'h66);
        clear_inputs();
        tick();
        chk("to_err_sticky", {31'd0, Err}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
